// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=3 (7,5) convolutional encoder; appends two zero-tail symbols per frame.
// Latency: bit accepted at edge n is on out_sym in cycle n+1 (one registered output slot).
// Backpressure: out_ready low holds the slot, which drops in_ready and pauses tail generation.
module conv_encoder_tx #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] out_sym,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_tail,
    output logic       out_last,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    // Index of the final information bit of a frame (counter starts at 0).
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    logic [1:0] state;
    logic [1:0] sr;
    logic [7:0] bit_cnt;
    logic       tail_cnt;

    logic       slot_free;
    logic       in_take;
    logic       tail_take;
    logic       load;
    logic       enc_bit;
    logic [1:0] sym_next;

    assign slot_free = !out_valid || out_ready;
    // Reset gates the handshake so nothing is accepted during the reset cycle.
    assign in_ready  = rst && slot_free && (state != ST_TAIL);
    assign in_take   = in_valid && in_ready;
    assign tail_take = rst && (state == ST_TAIL) && slot_free;
    assign load      = in_take || tail_take;
    // Flush symbols are produced by shifting zeros through the register.
    assign enc_bit   = (state == ST_TAIL) ? 1'b0 : in_bit;
    assign sym_next  = {enc_bit ^ sr[0] ^ sr[1], enc_bit ^ sr[1]};
    assign busy      = rst && ((state != ST_IDLE) || out_valid);

    // Frame FSM: counts information bits, then two tail bits, and returns sr to 00.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            sr       <= 2'b00;
            bit_cnt  <= 8'd0;
            tail_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_take) begin
                        sr <= {sr[0], enc_bit};
                        if (FRAME_LEN == 1) begin
                            state <= ST_TAIL;
                        end else begin
                            bit_cnt <= 8'd1;
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (in_take) begin
                        sr <= {sr[0], enc_bit};
                        if (bit_cnt == LAST_IDX) begin
                            bit_cnt <= 8'd0;
                            state   <= ST_TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (slot_free) begin
                        if (tail_cnt) begin
                            tail_cnt <= 1'b0;
                            sr       <= 2'b00;
                            state    <= ST_IDLE;
                        end else begin
                            tail_cnt <= 1'b1;
                            sr       <= {sr[0], 1'b0};
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output slot: reload on any new symbol, otherwise clear once downstream takes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sym   <= sym_next;
            out_tail  <= (state == ST_TAIL);
            out_last  <= (state == ST_TAIL) && tail_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/conv_encoder_tx.md
# conv_encoder_tx

Rate-1/2, constraint-length-3 convolutional encoder with zero-tail frame termination. It sits at the transmit end of the Viterbi link and produces the 2-bit code symbols that the decoder's branch-metric, ACS and survivor-memory stages consume. It accepts information bits over a valid/ready handshake and emits one symbol per accepted bit. It then appends K-1 = 2 flush symbols so every frame ends in trellis state 00, the state the decoder's traceback starts from.

## Interface
Parameters:
- FRAME_LEN, 8, information bits per frame (legal range 1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- in_bit  in  1  information bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- out_sym  out  2  code symbol {c0,c1}; c0 on bit 1, c1 on bit 0.
- out_valid  out  1  out_sym is valid.
- out_ready  in  1  downstream accepts out_sym this cycle.
- out_tail  out  1  current symbol is a flush symbol.
- out_last  out  1  current symbol is the final symbol of the frame (second tail).
- busy  out  1  a frame is in progress (state != IDLE), or a symbol is still pending.

## Operation
- Generators: G0 = 111 (octal 7), G1 = 101 (octal 5).
- Shift register: sr[1:0]. sr[0] holds the previous bit; sr[1] holds the bit before it.
- Encoding of bit b: c0 = b ^ sr[0] ^ sr[1]; c1 = b ^ sr[1]; then sr <= {sr[0], b}.
- FSM states:
  - IDLE: sr = 00, bit counter = 0. An accepted bit starts a frame and moves the FSM to DATA. A frame with FRAME_LEN = 1 goes straight to TAIL.
  - DATA: each accepted bit increments the counter. When the FRAME_LEN-th bit is accepted, the FSM moves to TAIL.
  - TAIL: the encoder generates internal b = 0 whenever the output slot is free; in_ready = 0. The tail counter runs 0..1. After the second tail symbol is loaded, the FSM moves to IDLE with sr = 00.
- Output slot: one registered stage.
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && (state != TAIL).
  - A symbol is loaded when (in_valid && in_ready) or (state == TAIL && slot_free).
  - out_valid clears when out_ready is high and no new symbol is loaded in the same cycle.
- out_sym, out_tail and out_last stay stable while out_valid && !out_ready.
- out_tail = 1 for both flush symbols. out_last = 1 only with the second flush symbol.
- Counter widths: bit counter is 8 bits; tail counter is 1 bit. Neither counter wraps within a frame.
- Reset (rst = 0 at a clock edge, in any state, including mid-frame or mid-tail):
  - FSM goes to IDLE; sr, both counters, out_valid, out_tail and out_last go to 0; out_sym goes to 00.
  - A partial frame is discarded and no flush is emitted.
  - in_ready and busy are 0 during the reset cycle.

## Timing
- Latency: the bit accepted at edge n appears on out_sym after edge n, i.e. valid in cycle n+1.
- Throughput: one symbol per cycle with out_ready held high. The frame occupies FRAME_LEN + 2 output cycles.
- The first bit of the next frame can be accepted in the cycle after the last tail symbol is loaded. There is no dead cycle.
- Simultaneous events:
  - Downstream takes a symbol and a new bit is accepted in the same cycle: the slot reloads and out_valid stays 1.
  - Input holds in_valid while the FSM is in TAIL: the bit is held off (in_ready = 0) and not consumed.
- Reset outputs: in_ready = 0 during reset and 1 from the first cycle after reset is released; busy = 0.

## Test plan
- FRAME_LEN = 4, bits 1,0,1,1 with out_ready = 1 -> out_sym 11,10,00,01 then tail 01,11. out_tail is high on the last two symbols and out_last on the final one; busy drops after out_last is taken.
- All-zero frame of 8 bits -> ten symbols of 00, and sr = 00 at the end.
- Backpressure: out_ready = 0 for 3 cycles mid-frame -> in_ready = 0, out_sym held stable, no bit lost or duplicated; the sequence matches the golden (7,5) model.
- Back-to-back frames (1,0,1,1 then 1,1,0,0) with in_valid held high -> symbols 11,10,00,01,01,11,11,01,01,11,00,00 with no idle cycle.
- rst = 0 asserted in TAIL after the first flush symbol -> next cycle out_valid = 0 and the FSM is in IDLE. A new frame 1,0,1,1 then encodes from sr = 00 as 11,10,00,01,01,11.
- FRAME_LEN = 1, bit 1 -> 11,10,11 with out_last on the third symbol.
